writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage of the control processor, the consumer end of the memory/writeback pipeline register. It takes the registered writeback bundle and commits it. Register-file writes complete in one cycle. 512-bit FFT writes are serialized into 32-bit beats over a valid/ready port. Synth commands are held until the synth accepts them. While a multi-cycle commit is in progress, the unit asserts `stall_out` back to the pipeline.

## Interface
- `INW`, 512, width of writeback data bundle
- `ADDRW`, 32, FFT word address width
- `DATAW`, 32, register/beat data width; `INW` must be a multiple of `DATAW`
- `IMMW`, 11, synth immediate width
- `REGW`, 3, register index width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `valid_in`, `fft_wr_en_in`, `reg_wr_en_in`, `syn_in`, `set_en_in`, `set_freq_in`  in  1 each  writeback bundle flags
- `wr_reg_in`  in  REGW  destination register
- `imm_in`  in  IMMW  synth immediate
- `addr_in`  in  ADDRW  FFT base word address
- `data_in`  in  INW  writeback data
- `stall_out`  out  1  hold upstream pipe
- `rf_wr_en`  out  1  register-file write strobe
- `rf_wr_reg`  out  REGW  register-file write index
- `rf_wr_data`  out  DATAW  register-file write data
- `fft_valid`  out  1  FFT beat valid
- `fft_ready`  in  1  FFT beat ready
- `fft_addr`  out  ADDRW  FFT beat address
- `fft_data`  out  DATAW  FFT beat data
- `fft_last`  out  1  final beat of burst
- `syn_valid`  out  1  synth command valid
- `syn_ready`  in  1  synth command ready
- `syn_set_en`, `syn_set_freq`  out  1 each  synth command flags
- `syn_imm`  out  IMMW  synth immediate

## Operation
- States: IDLE, FFT_BURST, SYN_HOLD.
- `stall_out` is Moore: high iff state is not IDLE.
- Acceptance: in IDLE with `valid_in`=1, the bundle is latched at the clock edge. All outputs are registered.
- Register write:
  - If `reg_wr_en_in`, then for exactly one cycle after acceptance `rf_wr_en`=1, `rf_wr_reg`=`wr_reg_in`, `rf_wr_data`=`data_in[DATAW-1:0]`.
  - Otherwise `rf_wr_en`=0.
- Next state from IDLE: `fft_wr_en_in` → FFT_BURST; else `syn_in` → SYN_HOLD; else stay in IDLE.
- FFT_BURST:
  - BEATS = INW/DATAW = 16. Beat k carries `data[k*DATAW +: DATAW]`, low word first.
  - `fft_addr` = latched addr + k, modulo 2^ADDRW (wraps silently).
  - `fft_last` is high on beat BEATS-1.
  - A beat transfers on `fft_valid && fft_ready`. `fft_valid`, `fft_addr`, `fft_data` and `fft_last` are held stable until the beat transfers.
  - After the last beat transfers: go to SYN_HOLD if the latched syn flag is set, else IDLE.
- SYN_HOLD:
  - `syn_valid`=1, with the latched `set_en`, `set_freq` and `imm` on the command outputs, held until `syn_ready`.
  - Then return to IDLE.
- Combined bundles: the reg write is issued first (cycle 1), the FFT burst overlaps it from cycle 1, and the syn command is issued last.
- A `valid_in` bundle with no enables set is accepted with no effect.
- No flush input: once accepted, a commit always completes. Only `rst` aborts it.
- Reset: state IDLE, beat counter 0, and every output 0 (`stall_out`, `rf_*`, `fft_valid`, `fft_addr`, `fft_data`, `fft_last`, `syn_*`). Reset mid-burst discards the remaining beats.

## Timing
- Acceptance edge is E0.
- Reg-only bundle: `rf_wr_en` high in cycle 1. `stall_out` never asserts.
- FFT burst with `fft_ready` held at 1:
  - Beats in cycles 1..16; `stall_out` high in cycles 1..16.
  - Cycle 17 is IDLE, so the next acceptance is at the end of cycle 17.
- Each cycle of `fft_ready`=0 lengthens the burst by one cycle.
- Syn-only bundle with `syn_ready`=1: `syn_valid` high in cycle 1, IDLE in cycle 2.
- Back-to-back reg-only bundles are accepted every cycle.

## Configuration
- `WB_SYN_EN` defined: synth path present as described.
- `WB_SYN_EN` undefined:
  - SYN_HOLD is removed.
  - `syn_in`, `set_en_in`, `set_freq_in`, `imm_in` and `syn_ready` are ignored.
  - `syn_valid`, `syn_set_en`, `syn_set_freq` and `syn_imm` are tied to 0.
  - A burst always ends in IDLE.

## Structure
- Package `wb_pkg`: state enum `wb_state_t`; constant `WB_BEATS`; beat-index width `$clog2(WB_BEATS)`.
- Sub-module `fft_beat_serializer`:
  - Loads the INW data and ADDRW base address.
  - Owns the beat counter, the word mux and the address adder.
  - Drives `fft_valid`, `fft_addr`, `fft_data` and `fft_last`, and reports `done`.

## Test plan
- Reset → all outputs 0; `stall_out`=0. Assert `rst` on the same edge as a `valid_in` → no acceptance.
- Reg write, `wr_reg_in`=5, low word 0xDEADBEEF → cycle 1: `rf_wr_en`=1, `rf_wr_reg`=5, `rf_wr_data`=0xDEADBEEF; cycle 2: `rf_wr_en`=0; `stall_out`=0 throughout.
- FFT burst, `addr_in`=0x100, word k = k, `fft_ready`=1 → 16 beats, addresses 0x100..0x10F, data 0..15; `fft_last` only on address 0x10F; `stall_out` high for exactly 16 cycles.
- Backpressure, `addr_in`=0xFFFFFFF8, `fft_ready` alternating 0/1 → outputs stable while ready=0; addresses 0xFFFFFFF8..0xFFFFFFFF then 0x0..0x7; burst lasts 32 cycles.
- Combined reg+fft+syn bundle (`set_freq_in`=1, `imm_in`=0x2A), `syn_ready` low for 3 cycles after `syn_valid` rises → rf write in cycle 1, then 16 beats, then `syn_valid`=1 with `syn_imm`=0x2A for 4 cycles; IDLE on the next cycle.
- `rst` during beat 7 → next cycle all outputs 0 and state IDLE; a fresh reg-only bundle is then accepted and committed in one cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
//   Shared types and constants for the writeback stage.
//   - wb_state_t   : writeback FSM state (IDLE / FFT_BURST / SYN_HOLD)
//   - WB_*         : default bundle geometry
//   - WB_BEATS     : number of DATAW beats in one INW-wide FFT write
//   - WB_BEAT_IDXW : width of a beat index
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_INW   = 512;
  localparam int WB_ADDRW = 32;
  localparam int WB_DATAW = 32;
  localparam int WB_IMMW  = 11;
  localparam int WB_REGW  = 3;

  localparam int WB_BEATS    = WB_INW / WB_DATAW;
  localparam int WB_BEAT_IDXW = $clog2(WB_BEATS);

  typedef enum logic [1:0] {
    WB_IDLE      = 2'd0,
    WB_FFT_BURST = 2'd1,
    WB_SYN_HOLD  = 2'd2
  } wb_state_t;

endpackage : wb_pkg

// File: rtl/fft_beat_serializer.sv
// -----------------------------------------------------------------------------
// fft_beat_serializer
//   Splits one INW-bit FFT write into INW/DATAW beats of DATAW bits, low word
//   first, on a valid/ready port. Beat k goes to base address + k (wrapping
//   modulo 2^ADDRW). All beat outputs come straight from flops and are held
//   until the beat transfers.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   load       : latch data_in/addr_in and start a burst (only when idle)
//   data_in    : INW-bit write data
//   addr_in    : base word address
//   fft_ready  : sink accepts the current beat
//   fft_valid  : beat valid
//   fft_addr   : beat address
//   fft_data   : beat data
//   fft_last   : final beat of the burst
//   done       : pulses in the cycle the final beat transfers
// -----------------------------------------------------------------------------
module fft_beat_serializer #(
  parameter int INW   = 512,
  parameter int DATAW = 32,
  parameter int ADDRW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [INW-1:0]   data_in,
  input  logic [ADDRW-1:0] addr_in,
  input  logic             fft_ready,
  output logic             fft_valid,
  output logic [ADDRW-1:0] fft_addr,
  output logic [DATAW-1:0] fft_data,
  output logic             fft_last,
  output logic             done
);

  localparam int BEATS = INW / DATAW;
  localparam int IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BEATS - 1);

  logic [DATAW-1:0] words_q [BEATS];

  logic [IDXW-1:0]  beat_q,  beat_d;
  logic             valid_q, valid_d;
  logic [ADDRW-1:0] addr_q,  addr_d;
  logic [DATAW-1:0] data_q,  data_d;
  logic             last_q,  last_d;
  logic [IDXW-1:0]  beat_nxt;
  logic             xfer;

  assign xfer     = valid_q & fft_ready;
  assign beat_nxt = beat_q + IDXW'(1);

  // NOTE: the word buffer is pure datapath and is only read after a load has
  // written it, so it carries no reset; resetting it would only add fan-out.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < BEATS; k++) begin
        words_q[k] <= data_in[k*DATAW +: DATAW];
      end
    end
  end

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    beat_d  = beat_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      beat_d  = '0;
      valid_d = 1'b1;
      addr_d  = addr_in;
      data_d  = data_in[DATAW-1:0];
      last_d  = (BEATS == 1);
    end else if (xfer) begin
      if (last_q) begin
        beat_d  = '0;
        valid_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        last_d  = 1'b0;
      end else begin
        // Pre-compute the next beat so the outputs stay registered.
        beat_d = beat_nxt;
        addr_d = addr_q + ADDRW'(1);
        data_d = words_q[beat_nxt];
        last_d = (beat_nxt == LAST_IDX);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign fft_valid = valid_q;
  assign fft_addr  = addr_q;
  assign fft_data  = data_q;
  assign fft_last  = last_q;
  assign done      = xfer & last_q;

endmodule : fft_beat_serializer

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//   Writeback stage of the control processor. Accepts one writeback bundle per
//   idle cycle and commits it: a single-cycle register-file write, a serialized
//   INW-bit FFT write, and a synth command held until the synth accepts it.
//   The reg write is issued in the cycle after acceptance, the FFT burst
//   overlaps it, and the synth command goes out last. stall_out is high
//   whenever the FSM is not IDLE.
//
// Configuration
//   WB_SYN_EN : when defined the synth command path exists. When undefined
//               the synth inputs are ignored, the synth outputs are tied to
//               0 and the FSM never enters SYN_HOLD.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   valid_in                 : bundle valid (accepted only in IDLE)
//   fft_wr_en_in             : bundle carries an FFT write
//   reg_wr_en_in             : bundle carries a register write
//   syn_in                   : bundle carries a synth command
//   set_en_in, set_freq_in   : synth command flags
//   wr_reg_in                : destination register
//   imm_in                   : synth immediate
//   addr_in                  : FFT base word address
//   data_in                  : writeback data
//   stall_out                : hold the upstream pipe
//   rf_wr_en/_reg/_data      : register-file write port
//   fft_valid/_ready/_addr/_data/_last : FFT beat port
//   syn_valid/_ready         : synth command handshake
//   syn_set_en/_set_freq/_imm: synth command payload
// -----------------------------------------------------------------------------
module writeback_unit
  import wb_pkg::*;
#(
  parameter int INW   = WB_INW,
  parameter int ADDRW = WB_ADDRW,
  parameter int DATAW = WB_DATAW,
  parameter int IMMW  = WB_IMMW,
  parameter int REGW  = WB_REGW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             fft_wr_en_in,
  input  logic             reg_wr_en_in,
  input  logic             syn_in,
  input  logic             set_en_in,
  input  logic             set_freq_in,
  input  logic [REGW-1:0]  wr_reg_in,
  input  logic [IMMW-1:0]  imm_in,
  input  logic [ADDRW-1:0] addr_in,
  input  logic [INW-1:0]   data_in,
  output logic             stall_out,
  output logic             rf_wr_en,
  output logic [REGW-1:0]  rf_wr_reg,
  output logic [DATAW-1:0] rf_wr_data,
  output logic             fft_valid,
  input  logic             fft_ready,
  output logic [ADDRW-1:0] fft_addr,
  output logic [DATAW-1:0] fft_data,
  output logic             fft_last,
  output logic             syn_valid,
  input  logic             syn_ready,
  output logic             syn_set_en,
  output logic             syn_set_freq,
  output logic [IMMW-1:0]  syn_imm
);

  wb_state_t state_q, state_d;

  logic             accept;
  logic             fft_load;
  logic             fft_done;

  logic             rf_wr_en_q,   rf_wr_en_d;
  logic [REGW-1:0]  rf_wr_reg_q,  rf_wr_reg_d;
  logic [DATAW-1:0] rf_wr_data_q, rf_wr_data_d;

  assign accept   = (state_q == WB_IDLE) & valid_in;
  assign fft_load = accept & fft_wr_en_in;

  fft_beat_serializer #(
    .INW   (INW),
    .DATAW (DATAW),
    .ADDRW (ADDRW)
  ) u_fft_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (fft_load),
    .data_in   (data_in),
    .addr_in   (addr_in),
    .fft_ready (fft_ready),
    .fft_valid (fft_valid),
    .fft_addr  (fft_addr),
    .fft_data  (fft_data),
    .fft_last  (fft_last),
    .done      (fft_done)
  );

`ifdef WB_SYN_EN
  // Synth command captured at acceptance, replayed once the burst ends.
  logic            syn_pend_q;
  logic            set_en_q;
  logic            set_freq_q;
  logic [IMMW-1:0] imm_q;

  logic            syn_valid_q,    syn_valid_d;
  logic            syn_set_en_q,   syn_set_en_d;
  logic            syn_set_freq_q, syn_set_freq_d;
  logic [IMMW-1:0] syn_imm_q,      syn_imm_d;
`else
  // Synth inputs have no function in this build.
  logic unused_syn;
  assign unused_syn = ^{syn_in, set_en_in, set_freq_in, imm_in, syn_ready};
`endif

  // ---------------------------------------------------------------------------
  // Process 1: state and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WB_IDLE;
      rf_wr_en_q   <= 1'b0;
      rf_wr_reg_q  <= '0;
      rf_wr_data_q <= '0;
`ifdef WB_SYN_EN
      syn_pend_q     <= 1'b0;
      set_en_q       <= 1'b0;
      set_freq_q     <= 1'b0;
      imm_q          <= '0;
      syn_valid_q    <= 1'b0;
      syn_set_en_q   <= 1'b0;
      syn_set_freq_q <= 1'b0;
      syn_imm_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_reg_q  <= rf_wr_reg_d;
      rf_wr_data_q <= rf_wr_data_d;
`ifdef WB_SYN_EN
      if (accept) begin
        syn_pend_q <= syn_in;
        set_en_q   <= set_en_in;
        set_freq_q <= set_freq_in;
        imm_q      <= imm_in;
      end
      syn_valid_q    <= syn_valid_d;
      syn_set_en_q   <= syn_set_en_d;
      syn_set_freq_q <= syn_set_freq_d;
      syn_imm_q      <= syn_imm_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_IDLE: begin
        if (valid_in) begin
          if (fft_wr_en_in) begin
            state_d = WB_FFT_BURST;
          end
`ifdef WB_SYN_EN
          else if (syn_in) begin
            state_d = WB_SYN_HOLD;
          end
`endif
        end
      end
      WB_FFT_BURST: begin
        if (fft_done) begin
`ifdef WB_SYN_EN
          state_d = syn_pend_q ? WB_SYN_HOLD : WB_IDLE;
`else
          state_d = WB_IDLE;
`endif
        end
      end
      WB_SYN_HOLD: begin
`ifdef WB_SYN_EN
        if (syn_ready) begin
          state_d = WB_IDLE;
        end
`else
        state_d = WB_IDLE;
`endif
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: output next-values (registered in process 1)
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_wr_en_d   = accept & reg_wr_en_in;
    rf_wr_reg_d  = '0;
    rf_wr_data_d = '0;
    if (rf_wr_en_d) begin
      rf_wr_reg_d  = wr_reg_in;
      rf_wr_data_d = data_in[DATAW-1:0];
    end
`ifdef WB_SYN_EN
    syn_valid_d    = (state_d == WB_SYN_HOLD);
    syn_set_en_d   = 1'b0;
    syn_set_freq_d = 1'b0;
    syn_imm_d      = '0;
    if (syn_valid_d) begin
      // Entering straight from IDLE the command is still on the inputs;
      // after a burst it comes from the captured copy.
      if (state_q == WB_IDLE) begin
        syn_set_en_d   = set_en_in;
        syn_set_freq_d = set_freq_in;
        syn_imm_d      = imm_in;
      end else begin
        syn_set_en_d   = set_en_q;
        syn_set_freq_d = set_freq_q;
        syn_imm_d      = imm_q;
      end
    end
`endif
  end

  assign stall_out  = (state_q != WB_IDLE);
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_reg  = rf_wr_reg_q;
  assign rf_wr_data = rf_wr_data_q;

`ifdef WB_SYN_EN
  assign syn_valid    = syn_valid_q;
  assign syn_set_en   = syn_set_en_q;
  assign syn_set_freq = syn_set_freq_q;
  assign syn_imm      = syn_imm_q;
`else
  assign syn_valid    = 1'b0;
  assign syn_set_en   = 1'b0;
  assign syn_set_freq = 1'b0;
  assign syn_imm      = '0;
`endif

endmodule : writeback_unit

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//   Directed self-checking bench for writeback_unit. Inputs are driven 1 ns
//   after the rising edge and outputs are sampled at that same point, so each
//   sample shows the cycle that follows the edge. The synth checks follow the
//   WB_SYN_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

  localparam int INW   = 512;
  localparam int ADDRW = 32;
  localparam int DATAW = 32;
  localparam int IMMW  = 11;
  localparam int REGW  = 3;
  localparam int BEATS = INW / DATAW;

  logic             clk;
  logic             rst;
  logic             valid_in, fft_wr_en_in, reg_wr_en_in, syn_in;
  logic             set_en_in, set_freq_in;
  logic [REGW-1:0]  wr_reg_in;
  logic [IMMW-1:0]  imm_in;
  logic [ADDRW-1:0] addr_in;
  logic [INW-1:0]   data_in;
  logic             stall_out;
  logic             rf_wr_en;
  logic [REGW-1:0]  rf_wr_reg;
  logic [DATAW-1:0] rf_wr_data;
  logic             fft_valid, fft_ready, fft_last;
  logic [ADDRW-1:0] fft_addr;
  logic [DATAW-1:0] fft_data;
  logic             syn_valid, syn_ready, syn_set_en, syn_set_freq;
  logic [IMMW-1:0]  syn_imm;

  int n_vec  = 0;
  int n_miss = 0;

  writeback_unit #(
    .INW (INW), .ADDRW (ADDRW), .DATAW (DATAW), .IMMW (IMMW), .REGW (REGW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .fft_wr_en_in (fft_wr_en_in),
    .reg_wr_en_in (reg_wr_en_in),
    .syn_in       (syn_in),
    .set_en_in    (set_en_in),
    .set_freq_in  (set_freq_in),
    .wr_reg_in    (wr_reg_in),
    .imm_in       (imm_in),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .stall_out    (stall_out),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_reg    (rf_wr_reg),
    .rf_wr_data   (rf_wr_data),
    .fft_valid    (fft_valid),
    .fft_ready    (fft_ready),
    .fft_addr     (fft_addr),
    .fft_data     (fft_data),
    .fft_last     (fft_last),
    .syn_valid    (syn_valid),
    .syn_ready    (syn_ready),
    .syn_set_en   (syn_set_en),
    .syn_set_freq (syn_set_freq),
    .syn_imm      (syn_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout, want $finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in     = 1'b0;
    fft_wr_en_in = 1'b0;
    reg_wr_en_in = 1'b0;
    syn_in       = 1'b0;
    set_en_in    = 1'b0;
    set_freq_in  = 1'b0;
    wr_reg_in    = '0;
    imm_in       = '0;
    addr_in      = '0;
    data_in      = '0;
  endtask

  // Word k of data_in = wbase + k.
  task automatic fill_words(input logic [31:0] wbase);
    for (int k = 0; k < BEATS; k++) begin
      data_in[k*DATAW +: DATAW] = wbase + 32'(k);
    end
  endtask

  task automatic check_quiet(input string tag);
    check($sformatf("%s.stall", tag),        64'(stall_out),    64'd0);
    check($sformatf("%s.rf_wr_en", tag),     64'(rf_wr_en),     64'd0);
    check($sformatf("%s.rf_wr_reg", tag),    64'(rf_wr_reg),    64'd0);
    check($sformatf("%s.rf_wr_data", tag),   64'(rf_wr_data),   64'd0);
    check($sformatf("%s.fft_valid", tag),    64'(fft_valid),    64'd0);
    check($sformatf("%s.fft_addr", tag),     64'(fft_addr),     64'd0);
    check($sformatf("%s.fft_data", tag),     64'(fft_data),     64'd0);
    check($sformatf("%s.fft_last", tag),     64'(fft_last),     64'd0);
    check($sformatf("%s.syn_valid", tag),    64'(syn_valid),    64'd0);
    check($sformatf("%s.syn_set_en", tag),   64'(syn_set_en),   64'd0);
    check($sformatf("%s.syn_set_freq", tag), 64'(syn_set_freq), 64'd0);
    check($sformatf("%s.syn_imm", tag),      64'(syn_imm),      64'd0);
  endtask

  // Entered in cycle 1 of a burst. With alt=1 fft_ready is 0 in odd cycles
  // and 1 in even ones, so each beat is shown for two cycles. Returns in the
  // first cycle after the burst.
  task automatic check_burst(input string tag, input logic [31:0] a0,
                             input logic [31:0] w0, input bit alt);
    int ncyc;
    int beat;
    logic [31:0] exp_addr;
    ncyc = alt ? 2 * BEATS : BEATS;
    for (int c = 1; c <= ncyc; c++) begin
      beat     = alt ? (c - 1) / 2 : c - 1;
      exp_addr = a0 + 32'(beat);
      check($sformatf("%s.c%0d.valid", tag, c), 64'(fft_valid), 64'd1);
      check($sformatf("%s.c%0d.addr", tag, c),  64'(fft_addr),  64'(exp_addr));
      check($sformatf("%s.c%0d.data", tag, c),  64'(fft_data),  64'(w0 + 32'(beat)));
      check($sformatf("%s.c%0d.last", tag, c),  64'(fft_last),  64'(beat == BEATS - 1));
      check($sformatf("%s.c%0d.stall", tag, c), 64'(stall_out), 64'd1);
      if (alt) fft_ready = (c % 2 == 0);
      step();
    end
  endtask

  initial begin
    clear_inputs();
    rst       = 1'b1;
    fft_ready = 1'b0;
    syn_ready = 1'b0;

    // Reset state.
    step();
    step();
    check_quiet("reset");

    // Reset wins over a bundle on the same edge.
    valid_in = 1'b1; reg_wr_en_in = 1'b1; fft_wr_en_in = 1'b1; syn_in = 1'b1;
    wr_reg_in = 3'd6; fill_words(32'h5555_0000);
    step();
    check_quiet("rst_vs_valid");
    rst = 1'b0;
    clear_inputs();
    step();
    check_quiet("after_rst");

    // Single register write.
    valid_in = 1'b1; reg_wr_en_in = 1'b1; wr_reg_in = 3'd5;
    data_in[31:0] = 32'hDEAD_BEEF;
    step();
    clear_inputs();
    check("reg.c1.en",    64'(rf_wr_en),   64'd1);
    check("reg.c1.reg",   64'(rf_wr_reg),  64'd5);
    check("reg.c1.data",  64'(rf_wr_data), 64'hDEAD_BEEF);
    check("reg.c1.stall", 64'(stall_out),  64'd0);
    step();
    check("reg.c2.en",    64'(rf_wr_en),   64'd0);
    check("reg.c2.stall", 64'(stall_out),  64'd0);

    // Back-to-back register writes, one per cycle.
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1; reg_wr_en_in = 1'b1;
      wr_reg_in = 3'(i + 1); data_in[31:0] = 32'h0000_0100 + 32'(i);
      step();
      check($sformatf("b2b%0d.en", i),    64'(rf_wr_en),   64'd1);
      check($sformatf("b2b%0d.reg", i),   64'(rf_wr_reg),  64'(i + 1));
      check($sformatf("b2b%0d.data", i),  64'(rf_wr_data), 64'h100 + 64'(i));
      check($sformatf("b2b%0d.stall", i), 64'(stall_out),  64'd0);
    end
    clear_inputs();
    step();
    check("b2b.end.en", 64'(rf_wr_en), 64'd0);

    // Bundle with no enables: accepted, no effect.
    valid_in = 1'b1;
    step();
    clear_inputs();
    check_quiet("noop");

    // FFT burst, ready held high.
    fft_ready = 1'b1;
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'h0000_0100;
    fill_words(32'h0);
    step();
    clear_inputs();
    check("fft.c1.rf_wr_en", 64'(rf_wr_en), 64'd0);
    check_burst("fft", 32'h0000_0100, 32'h0, 1'b0);
    check("fft.c17.stall", 64'(stall_out), 64'd0);
    check("fft.c17.valid", 64'(fft_valid), 64'd0);

    // FFT burst with alternating backpressure and address wrap.
    fft_ready = 1'b0;
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'hFFFF_FFF8;
    fill_words(32'hA000_0000);
    step();
    clear_inputs();
    check_burst("bp", 32'hFFFF_FFF8, 32'hA000_0000, 1'b1);
    check("bp.c33.stall", 64'(stall_out), 64'd0);
    check("bp.c33.valid", 64'(fft_valid), 64'd0);

    // Combined reg + FFT + synth bundle.
    fft_ready = 1'b1;
    syn_ready = 1'b0;
    valid_in = 1'b1; reg_wr_en_in = 1'b1; fft_wr_en_in = 1'b1; syn_in = 1'b1;
    set_freq_in = 1'b1; imm_in = 11'h02A; wr_reg_in = 3'd3;
    addr_in = 32'h0000_0040; fill_words(32'hC0DE_0000);
    step();
    clear_inputs();
    check("comb.c1.rf_en",   64'(rf_wr_en),   64'd1);
    check("comb.c1.rf_reg",  64'(rf_wr_reg),  64'd3);
    check("comb.c1.rf_data", 64'(rf_wr_data), 64'hC0DE_0000);
    check("comb.c1.syn",     64'(syn_valid),  64'd0);
    check_burst("comb", 32'h0000_0040, 32'hC0DE_0000, 1'b0);
`ifdef WB_SYN_EN
    for (int c = 17; c <= 20; c++) begin
      check($sformatf("comb.c%0d.syn_valid", c), 64'(syn_valid),    64'd1);
      check($sformatf("comb.c%0d.syn_imm", c),   64'(syn_imm),      64'h2A);
      check($sformatf("comb.c%0d.set_freq", c),  64'(syn_set_freq), 64'd1);
      check($sformatf("comb.c%0d.set_en", c),    64'(syn_set_en),   64'd0);
      check($sformatf("comb.c%0d.stall", c),     64'(stall_out),    64'd1);
      check($sformatf("comb.c%0d.fft_valid", c), 64'(fft_valid),    64'd0);
      syn_ready = (c == 20);
      step();
    end
    syn_ready = 1'b0;
    check("comb.c21.stall",     64'(stall_out), 64'd0);
    check("comb.c21.syn_valid", 64'(syn_valid), 64'd0);
`else
    check("comb.c17.stall",     64'(stall_out), 64'd0);
    check("comb.c17.syn_valid", 64'(syn_valid), 64'd0);
    check("comb.c17.syn_imm",   64'(syn_imm),   64'd0);
`endif

    // Synth-only bundle, synth ready immediately.
    syn_ready = 1'b1;
    valid_in = 1'b1; syn_in = 1'b1; set_en_in = 1'b1; imm_in = 11'h155;
    step();
    clear_inputs();
`ifdef WB_SYN_EN
    check("syn.c1.valid",  64'(syn_valid),  64'd1);
    check("syn.c1.set_en", 64'(syn_set_en), 64'd1);
    check("syn.c1.imm",    64'(syn_imm),    64'h155);
    check("syn.c1.stall",  64'(stall_out),  64'd1);
    step();
    check("syn.c2.valid",  64'(syn_valid),  64'd0);
    check("syn.c2.stall",  64'(stall_out),  64'd0);
`else
    check_quiet("syn_off");
`endif
    syn_ready = 1'b0;

    // Reset in the middle of a burst.
    fft_ready = 1'b1;
    valid_in = 1'b1; fft_wr_en_in = 1'b1; addr_in = 32'h0000_0200;
    fill_words(32'h0000_0300);
    step();
    clear_inputs();
    for (int c = 1; c < 8; c++) step();
    check("rstmid.c8.addr",  64'(fft_addr),  64'h207);
    check("rstmid.c8.data",  64'(fft_data),  64'h307);
    check("rstmid.c8.stall", 64'(stall_out), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_quiet("rstmid");
    valid_in = 1'b1; reg_wr_en_in = 1'b1; wr_reg_in = 3'd2;
    data_in[31:0] = 32'h1234_5678;
    step();
    clear_inputs();
    check("rstmid.reg.en",    64'(rf_wr_en),   64'd1);
    check("rstmid.reg.reg",   64'(rf_wr_reg),  64'd2);
    check("rstmid.reg.data",  64'(rf_wr_data), 64'h1234_5678);
    check("rstmid.reg.stall", 64'(stall_out),  64'd0);
    check("rstmid.reg.fft",   64'(fft_valid),  64'd0);
    step();
    check("rstmid.reg.c2.en", 64'(rf_wr_en),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_writeback_unit
